// File: rtl/red_pitaya_decimator_block.sv
// Block-average decimator: sums N = 2^k enabled samples and emits their shifted, saturated mean.
// Optional macro DECIMATOR_ROUNDING_EN selects round-half-up instead of truncation.
module red_pitaya_decimator_block #(
    parameter int SIGNALBITS = 14,
    parameter int MAXLOG2    = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [3:0]                   log2_dec,
    input  logic                         enable_i,
    input  logic signed [SIGNALBITS-1:0] dat_i,
    output logic signed [SIGNALBITS-1:0] dat_o,
    output logic                         valid_o
);

    localparam int AW = SIGNALBITS + MAXLOG2;
    localparam int SW = AW + 1;
    localparam logic [MAXLOG2:0]   ONE_N   = 1;
    localparam logic [MAXLOG2-1:0] CNT_ONE = 1;
    localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (SIGNALBITS - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SAT_MIN = -(SW'(1) <<< (SIGNALBITS - 1));

    logic [3:0]                   k;
    logic [3:0]                   k_clamp;
    logic [MAXLOG2-1:0]           cnt;
    logic signed [AW-1:0]         acc;
    logic [MAXLOG2:0]             last_cnt;
    logic                         last;
    logic signed [SW-1:0]         rnd;
    logic signed [SW-1:0]         sum;
    logic signed [SW-1:0]         avg;
    logic signed [SIGNALBITS-1:0] avg_sat;

    assign k_clamp  = (log2_dec > 4'(MAXLOG2)) ? 4'(MAXLOG2) : log2_dec;
    assign last_cnt = (ONE_N << k) - ONE_N;
    assign last     = ({1'b0, cnt} == last_cnt);

    always_comb begin
        rnd = '0;
`ifdef DECIMATOR_ROUNDING_EN
        // half an LSB of the output, so the shift rounds half-up
        if (k != 4'd0)
            rnd = SW'(1) <<< (k - 4'd1);
`endif
    end

    // one guard bit above the accumulator absorbs the final sample plus rounding
    assign sum = SW'(acc) + SW'(dat_i) + rnd;
    assign avg = sum >>> k;

    always_comb begin
        if (avg > SAT_MAX)
            avg_sat = SAT_MAX[SIGNALBITS-1:0];
        else if (avg < SAT_MIN)
            avg_sat = SAT_MIN[SIGNALBITS-1:0];
        else
            avg_sat = avg[SIGNALBITS-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc     <= '0;
            cnt     <= '0;
            dat_o   <= '0;
            valid_o <= 1'b0;
            k       <= k_clamp;
        end else if (k_clamp != k) begin
            // ratio change wins over a completing block: drop the partial sum
            k       <= k_clamp;
            acc     <= '0;
            cnt     <= '0;
            valid_o <= 1'b0;
        end else if (enable_i) begin
            if (last) begin
                dat_o   <= avg_sat;
                acc     <= '0;
                cnt     <= '0;
                valid_o <= 1'b1;
            end else begin
                acc     <= acc + AW'(dat_i);
                cnt     <= cnt + CNT_ONE;
                valid_o <= 1'b0;
            end
        end else begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_red_pitaya_decimator_block.sv
// Directed bench for red_pitaya_decimator_block with a queue-based averaging model.
module tb_red_pitaya_decimator_block;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [3:0]         log2_dec = 4'd2;
    logic               enable_i = 1'b0;
    logic signed [13:0] dat_i = '0;
    logic signed [13:0] dat_o;
    logic               valid_o;

    int checks = 0;
    int failures = 0;

    // model state
    int m_k = 2;
    int blk[$];
    int m_dat = 0;
    bit m_vld = 1'b0;

    red_pitaya_decimator_block #(.SIGNALBITS(14), .MAXLOG2(10)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .log2_dec(log2_dec), .enable_i(enable_i),
        .dat_i(dat_i), .dat_o(dat_o), .valid_o(valid_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int clampk(input int l);
        return (l > 10) ? 10 : l;
    endfunction

    function automatic int floor_div(input longint s, input longint n);
        longint q;
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return int'(q);
    endfunction

    // mean of a full block, rounded as the configured build requires, clipped to 14 bits
    function automatic int block_mean(input int k);
        longint s = 0;
        longint n = longint'(1) << k;
        int q;
        foreach (blk[i]) s += blk[i];
`ifdef DECIMATOR_ROUNDING_EN
        if (k > 0) s += n / 2;
`endif
        q = floor_div(s, n);
        if (q > 8191) q = 8191;
        if (q < -8192) q = -8192;
        return q;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input int l2, input int d);
        if (r) begin
            blk.delete(); m_dat = 0; m_vld = 0; m_k = clampk(l2);
        end else if (clampk(l2) != m_k) begin
            m_k = clampk(l2); blk.delete(); m_vld = 0;
        end else if (e) begin
            blk.push_back(d);
            if (blk.size() == (1 << m_k)) begin
                m_dat = block_mean(m_k); m_vld = 1; blk.delete();
            end else m_vld = 0;
        end else m_vld = 0;
    endtask

    task automatic step(input bit r, input bit e, input int l2, input int d);
        @(negedge clk_i);
        rst_i = r; enable_i = e; log2_dec = 4'(l2); dat_i = 14'(d);
        @(posedge clk_i);
        model_edge(r, e, l2, d);
        #1;
        chk("model_dat", int'(dat_o), m_dat);
        chk("model_vld", int'(valid_o), int'(m_vld));
    endtask

    int exp27;
    int pulses;
    bit e;
    int d;

    initial begin
        // reset
        step(1, 0, 2, 0);
        step(1, 1, 2, 55);
        chk("reset_dat", int'(dat_o), 0);
        chk("reset_vld", int'(valid_o), 0);

        // basic block of four
`ifdef DECIMATOR_ROUNDING_EN
        exp27 = 102;
`else
        exp27 = 101;
`endif
        step(0, 1, 2, 100); step(0, 1, 2, 101); step(0, 1, 2, 102);
        chk("partial_vld", int'(valid_o), 0);
        step(0, 1, 2, 103);
        chk("avg4_vld", int'(valid_o), 1);
        chk("avg4_dat", int'(dat_o), exp27);
        step(0, 0, 2, 0);
        chk("avg4_vld_drop", int'(valid_o), 0);
        chk("avg4_hold", int'(dat_o), exp27);

        // negative full scale, k=3
        step(0, 0, 3, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 3, -8191);
        chk("neg_dat", int'(dat_o), -8191);
        // positive full scale, k=1
        step(0, 0, 1, 0);
        step(0, 1, 1, 8191); step(0, 1, 1, 8191);
        chk("pos_dat", int'(dat_o), 8191);
        chk("pos_vld", int'(valid_o), 1);
        // most negative code
        step(0, 1, 1, -8192); step(0, 1, 1, -8192);
        chk("min_dat", int'(dat_o), -8192);

        // enable gaps
        step(0, 0, 2, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, (i % 2) == 0, 2, 4);
            if (i < 6) chk("gap_novld", int'(valid_o), 0);
        end
        chk("gap_vld", int'(valid_o), 0);
        chk("gap_dat", int'(dat_o), 4);

        // ratio change discards a partial block
        step(0, 1, 2, 50); step(0, 1, 2, 60);
        step(0, 1, 1, 999);
        chk("chg_novld", int'(valid_o), 0);
        step(0, 1, 1, 10);
        chk("chg_partial", int'(valid_o), 0);
        step(0, 1, 1, 20);
        chk("chg_vld", int'(valid_o), 1);
        chk("chg_dat", int'(dat_o), 15);

        // change coinciding with a completing sample
        step(0, 1, 1, 30);
        step(0, 1, 2, 40);
        chk("chg_prio_vld", int'(valid_o), 0);
        chk("chg_prio_dat", int'(dat_o), 15);

        // reset mid-block
        step(0, 1, 2, 1000); step(0, 1, 2, 1000); step(0, 1, 2, 1000);
        step(1, 0, 2, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 2, 7);
        chk("rst_mid_vld", int'(valid_o), 1);
        chk("rst_mid_dat", int'(dat_o), 7);

        // clamped ratio: 15 -> 1024
        step(0, 0, 15, 0);
        pulses = 0;
        for (int i = 0; i < 2048; i++) begin
            step(0, 1, 15, (i % 37) - 18);
            if (valid_o) pulses++;
            if (i == 1022) chk("clamp_early", int'(valid_o), 0);
            if (i == 1023) chk("clamp_first", int'(valid_o), 1);
        end
        chk("clamp_pulses", pulses, 2);

        // k=0 pass-through with random stream
        step(0, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            e = 1'($urandom_range(0, 1));
            d = int'($urandom_range(0, 16383)) - 8192;
            step(0, e, 0, d);
            chk("k0_vld", int'(valid_o), int'(e));
            if (e) chk("k0_dat", int'(dat_o), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/red_pitaya_decimator_block.md
RED_PITAYA_DECIMATOR_BLOCK -- requirements
Module: red_pitaya_decimator_block

Interface
REQ-001 SIGNALBITS, 14, bit width of the signed input and output samples.
REQ-002 MAXLOG2, 10, largest supported log2 of the decimation ratio; the accumulator is SIGNALBITS+MAXLOG2 bits wide.
REQ-003 clk_i  input  1  single clock for all logic, rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 log2_dec  input  4  log2 of the decimation ratio N = 2^k; values above MAXLOG2 clamp to MAXLOG2.
REQ-006 enable_i  input  1  sample strobe; dat_i is consumed only in cycles where it is high.
REQ-007 dat_i  input  SIGNALBITS signed  filtered sample from the upstream filter block output.
REQ-008 dat_o  output  SIGNALBITS signed  decimated average, held between updates.
REQ-009 valid_o  output  1  one-cycle pulse marking a new dat_o value.

Function
REQ-010 The block SHALL keep an internal k register equal to clamp(log2_dec, MAXLOG2), a sample counter cnt (MAXLOG2 bits) and a signed accumulator acc.
REQ-011 In a cycle with enable_i high and cnt < N-1, the block SHALL update acc <= acc + dat_i and cnt <= cnt + 1, with valid_o low on the next cycle.
REQ-012 In a cycle with enable_i high and cnt == N-1, the block SHALL register dat_o <= sat((acc + dat_i + r) >>> k), clear acc and cnt, and assert valid_o on the next cycle for exactly one cycle.
REQ-013 Latency SHALL be one clock cycle from the edge that samples the N-th input to the edge where dat_o and valid_o update.
REQ-014 With enable_i low, acc, cnt and dat_o SHALL hold, and valid_o SHALL be 0.
REQ-015 With k = 0, the block SHALL act as a one-cycle register: dat_o <= dat_i and valid_o <= enable_i.
REQ-016 The shift SHALL be arithmetic, so a negative average stays negative.
REQ-017 sat() SHALL clamp to [-2^(SIGNALBITS-1), 2^(SIGNALBITS-1)-1].
REQ-018 The accumulator SHALL never wrap, because N·max|dat_i| fits within SIGNALBITS+MAXLOG2 bits.
REQ-019 When clamp(log2_dec) differs from k, the block SHALL load the new k on the next edge, clear acc and cnt, discard the partial block, and keep valid_o low that cycle, even if enable_i was high.
REQ-020 A log2_dec change coinciding with a completing sample SHALL take priority; the completed block is discarded and no valid_o is produced.
REQ-021 The counter SHALL wrap from N-1 to 0 only through REQ-012 and SHALL never exceed N-1.

Reset
REQ-022 While rst_i is high at a rising edge, the block SHALL set acc = 0, cnt = 0, dat_o = 0, valid_o = 0 and k = clamp(log2_dec).
REQ-023 Reset asserted mid-block SHALL discard the partial accumulation, and the first block after release SHALL start at cnt = 0.
REQ-024 No output SHALL depend on any reset other than rst_i.

Configuration
REQ-025 Macro DECIMATOR_ROUNDING_EN: when defined, r = 2^(k-1) for k > 0 and r = 0 for k = 0, giving round-half-up.
REQ-026 When DECIMATOR_ROUNDING_EN is undefined, r = 0, giving truncation toward minus infinity, and the saturation logic MAY be omitted because the result cannot overflow.

Verification
REQ-027 Reset, then enable_i = 1, log2_dec = 2, dat_i = 100,101,102,103 -> one cycle after the 4th sample, valid_o = 1 and dat_o = 101 (102 with DECIMATOR_ROUNDING_EN); valid_o = 0 on the following cycle.
REQ-028 log2_dec = 3 with 8 samples of -8191 and ROUNDING_EN -> dat_o = -8191; log2_dec = 1 with inputs 8191,8191 -> dat_o = 8191 with no overflow.
REQ-029 log2_dec = 2 with enable_i toggling 1,0,1,0,... over inputs 4,4,4,4 -> valid_o appears one cycle after the 4th enabled sample, dat_o = 4, and the held values are unaffected by idle cycles.
REQ-030 After 2 samples at log2_dec = 2, change log2_dec to 1, then feed 10,20 -> no pulse for the partial block, then dat_o = 15.
REQ-031 Assert rst_i after 3 of 4 samples, release, then feed 4 samples of 7 -> single valid_o with dat_o = 7; log2_dec = 15 with MAXLOG2 = 10 -> valid_o every 1024 enabled samples.
REQ-032 log2_dec = 0 with a random stream -> dat_o equals dat_i delayed one cycle, and valid_o equals enable_i delayed one cycle.
